// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D-cache memory arbiter: line geometry,
// arbiter state encoding, owner encoding and the memory request payload.
package mem_arb_pkg;

   localparam int unsigned ADDR_W = 28;
   localparam int unsigned DATA_W = 128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2,
      RECOV = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } owner_e;

   typedef struct packed {
      logic              read;
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   // True while one of the caches owns the memory port
   function automatic logic is_granted(arb_state_e st);
      return (st == GNT_I) || (st == GNT_D);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side signals around the arbiter.
// slave: the arbiter's view; master: the caches/memory (environment) view.
interface mem_arbiter_if;

   // I-cache port
   logic                             i_read;
   logic [mem_arb_pkg::ADDR_W-1:0]   i_addr;
   logic [mem_arb_pkg::DATA_W-1:0]   i_rdata;
   logic                             i_ready;

   // D-cache port
   logic                             d_read;
   logic                             d_write;
   logic [mem_arb_pkg::ADDR_W-1:0]   d_addr;
   logic [mem_arb_pkg::DATA_W-1:0]   d_wdata;
   logic [mem_arb_pkg::DATA_W-1:0]   d_rdata;
   logic                             d_ready;

   // Memory port
   logic                             mem_read;
   logic                             mem_write;
   logic [mem_arb_pkg::ADDR_W-1:0]   mem_addr;
   logic [mem_arb_pkg::DATA_W-1:0]   mem_wdata;
   logic [mem_arb_pkg::DATA_W-1:0]   mem_rdata;
   logic                             mem_ready;

   // Status
   logic                             err_timeout;

   modport slave (
      input  i_read, i_addr,
      output i_rdata, i_ready,
      input  d_read, d_write, d_addr, d_wdata,
      output d_rdata, d_ready,
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready,
      output err_timeout
   );

   modport master (
      output i_read, i_addr,
      input  i_rdata, i_ready,
      output d_read, d_write, d_addr, d_wdata,
      input  d_rdata, d_ready,
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata, mem_ready,
      input  err_timeout
   );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Per-transaction watchdog: counts granted cycles without mem_ready and
// raises a sticky error once the count reaches TIMEOUT. Never aborts.
module mem_arb_watchdog #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_start,   // a new grant begins next cycle
   input  logic i_run,     // a grant is active this cycle
   input  logic i_done,    // memory answered this cycle
   output logic o_err
);

   localparam int unsigned     CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_err;
   logic             w_stall;

   assign w_stall   = i_run & ~i_done;
   // Saturate so a very long stall cannot wrap the counter
   assign w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

   // Stall counter: cleared on each new grant, advances on stalled cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_cnt <= '0;
      end else if (w_stall) begin
         r_cnt <= w_cnt_nxt;
      end
   end

   // Sticky flag: only reset clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_stall && (w_cnt_nxt == CNT_MAX)) begin
         r_err <= 1'b1;
      end
   end

   assign o_err = r_err;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-granular memory port between the I-cache and D-cache.
// One owner per transaction; request, ready and read data are routed to and
// from the owner only, with one recovery cycle between transactions.
// Optional build macro MEM_ARB_RR_EN: round-robin on contention instead of
// fixed D-over-I priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic           clk,
   input  logic           proc_reset_n,
   mem_arbiter_if.slave   bus
);

   arb_state_e        r_state;
   arb_state_e        w_state_nxt;
   logic              w_d_req;
   logic              w_i_req;
   logic              w_pick_d;
   logic              w_start;
   logic              w_run;
   logic              w_err;
   mem_req_t          w_req;
   logic              w_i_ready;
   logic              w_d_ready;
   logic [DATA_W-1:0] w_i_rdata;
   logic [DATA_W-1:0] w_d_rdata;

   assign w_d_req = bus.d_read | bus.d_write;
   assign w_i_req = bus.i_read;

`ifdef MEM_ARB_RR_EN
   owner_e r_last_owner;

   // On contention the port that did not win last time is picked
   always_comb begin
      w_pick_d = w_d_req;
      if (w_d_req && w_i_req) begin
         w_pick_d = (r_last_owner == OWNER_I);
      end
   end

   // Remember which port received the most recent grant
   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         r_last_owner <= OWNER_I;
      end else if (w_start) begin
         r_last_owner <= w_pick_d ? OWNER_D : OWNER_I;
      end
   end
`else
   // Fixed priority: any D request beats an I request
   assign w_pick_d = w_d_req;
`endif

   // State register
   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state plus grant-gated routing of request, ready and read data
   always_comb begin
      w_state_nxt = r_state;
      w_req       = '0;
      w_i_ready   = 1'b0;
      w_d_ready   = 1'b0;
      w_i_rdata   = '0;
      w_d_rdata   = '0;
      w_start     = 1'b0;
      w_run       = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_d_req || w_i_req) begin
               w_start     = 1'b1;
               w_state_nxt = w_pick_d ? GNT_D : GNT_I;
            end
         end

         GNT_I: begin
            w_run      = 1'b1;
            w_req.read = bus.i_read;
            w_req.addr = bus.i_addr;
            w_i_ready  = bus.mem_ready;
            w_i_rdata  = bus.mem_rdata;
            // Done, or the I-cache withdrew its request
            if (bus.mem_ready || !w_i_req) begin
               w_state_nxt = RECOV;
            end
         end

         GNT_D: begin
            w_run       = 1'b1;
            // A simultaneous read and write is treated as a write-back
            w_req.write = bus.d_write;
            w_req.read  = bus.d_read & ~bus.d_write;
            w_req.addr  = bus.d_addr;
            w_req.wdata = bus.d_wdata;
            w_d_ready   = bus.mem_ready;
            w_d_rdata   = bus.mem_rdata;
            if (bus.mem_ready || !w_d_req) begin
               w_state_nxt = RECOV;
            end
         end

         RECOV: begin
            // One quiet cycle so memory sees the request drop
            w_state_nxt = IDLE;
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   mem_arb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (proc_reset_n),
      .i_start (w_start),
      .i_run   (w_run),
      .i_done  (bus.mem_ready),
      .o_err   (w_err)
   );

   assign bus.mem_read    = w_req.read;
   assign bus.mem_write   = w_req.write;
   assign bus.mem_addr    = w_req.addr;
   assign bus.mem_wdata   = w_req.wdata;
   assign bus.i_ready     = w_i_ready;
   assign bus.i_rdata     = w_i_rdata;
   assign bus.d_ready     = w_d_ready;
   assign bus.d_rdata     = w_d_rdata;
   assign bus.err_timeout = w_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: reset table, directed multi-cycle sequences and
// randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int unsigned TIMEOUT = 8;

   logic clk = 1'b0;
   logic proc_reset_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   mem_arbiter_if bus ();

   mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .proc_reset_n (proc_reset_n),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   // Reference model state: who owns the port, whether a quiet cycle is due
   int   m_owner;    // 0 none, 1 I, 2 D
   logic m_recov;
   logic m_last_d;
   int   m_stall;
   logic m_err;

   typedef struct {
      logic        ir, dr, dw, rdy;
      logic        e_mr, e_mw, e_irdy, e_drdy;
      logic [27:0] e_addr;
   } vec_t;

   vec_t tbl [13];

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic ir, input logic dr, input logic dw, input logic rdy);
      bus.i_read    = ir;
      bus.d_read    = dr;
      bus.d_write   = dw;
      bus.mem_ready = rdy;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic model_reset();
      m_owner  = 0;
      m_recov  = 1'b0;
      m_last_d = 1'b0;
      m_stall  = 0;
      m_err    = 1'b0;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      proc_reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      proc_reset_n = 1'b1;
      model_reset();
   endtask

   // Compare every DUT output with what the owner rules predict
   task automatic check_model();
      logic own_i, own_d;
      own_i = (m_owner == 1);
      own_d = (m_owner == 2);
      chk1("mem_read", bus.mem_read, (own_i & bus.i_read) | (own_d & bus.d_read & ~bus.d_write));
      chk1("mem_write", bus.mem_write, own_d & bus.d_write);
      chkw("mem_addr", 128'(bus.mem_addr),
           own_i ? 128'(bus.i_addr) : (own_d ? 128'(bus.d_addr) : 128'(0)));
      chkw("mem_wdata", bus.mem_wdata, own_d ? bus.d_wdata : 128'(0));
      chk1("i_ready", bus.i_ready, own_i & bus.mem_ready);
      chk1("d_ready", bus.d_ready, own_d & bus.mem_ready);
      chkw("i_rdata", bus.i_rdata, own_i ? bus.mem_rdata : 128'(0));
      chkw("d_rdata", bus.d_rdata, own_d ? bus.mem_rdata : 128'(0));
      chk1("err_timeout", bus.err_timeout, m_err);
   endtask

   // Advance the model across one clock edge using the current inputs
   task automatic model_step();
      logic dq, iq, pick_d;
      dq = bus.d_read | bus.d_write;
      iq = bus.i_read;
      if (m_owner != 0) begin
         if (!bus.mem_ready) begin
            m_stall++;
            if (m_stall >= int'(TIMEOUT)) m_err = 1'b1;
         end
         if (bus.mem_ready || ((m_owner == 1) ? !iq : !dq)) begin
            m_owner = 0;
            m_recov = 1'b1;
         end
      end else if (m_recov) begin
         m_recov = 1'b0;
      end else if (dq || iq) begin
`ifdef MEM_ARB_RR_EN
         pick_d = (dq && iq) ? !m_last_d : dq;
`else
         pick_d = dq;
`endif
         m_owner  = pick_d ? 2 : 1;
         m_stall  = 0;
         m_last_d = pick_d;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic d_act;
      logic exp_d;

      bus.i_addr    = 28'h0000123;
      bus.d_addr    = 28'hBEEF000;
      bus.d_wdata   = {4{32'h1234_5678}};
      bus.mem_rdata = '0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);

      // ---------------- reset state ----------------
      do_reset();
      @(negedge clk);
      chk1("rst_mem_read", bus.mem_read, 1'b0);
      chk1("rst_mem_write", bus.mem_write, 1'b0);
      chkw("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
      chk1("rst_err", bus.err_timeout, 1'b0);
      next_cyc();

      // ---------------- table: cycle-by-cycle sequence from IDLE ----------------
      //              ir    dr    dw    rdy   e_mr  e_mw  e_ir  e_dr  e_addr
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 28'hBEEF000};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 28'hBEEF000};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 28'h0000123};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 28'h0000123};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 28'hBEEF000};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'hBEEF000};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0};
      for (int k = 0; k < 13; k++) begin
         drive(tbl[k].ir, tbl[k].dr, tbl[k].dw, tbl[k].rdy);
         @(negedge clk);
         chk1($sformatf("tbl%0d_mem_read", k), bus.mem_read, tbl[k].e_mr);
         chk1($sformatf("tbl%0d_mem_write", k), bus.mem_write, tbl[k].e_mw);
         chk1($sformatf("tbl%0d_i_ready", k), bus.i_ready, tbl[k].e_irdy);
         chk1($sformatf("tbl%0d_d_ready", k), bus.d_ready, tbl[k].e_drdy);
         chkw($sformatf("tbl%0d_mem_addr", k), 128'(bus.mem_addr), 128'(tbl[k].e_addr));
         next_cyc();
      end

      // ---------------- reset asserted mid-transaction ----------------
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      next_cyc();
      @(negedge clk);
      chk1("midrst_gntd_mw", bus.mem_write, 1'b1);
      #2;
      proc_reset_n = 1'b0;
      #1;
      chk1("midrst_async_mw", bus.mem_write, 1'b0);
      chk1("midrst_err", bus.err_timeout, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      bus.i_addr = 28'h0000123;
      next_cyc();
      proc_reset_n = 1'b1;

      // ---------------- I read, memory answers 5 cycles later ----------------
      @(negedge clk);
      chk1("iread_c0_idle", bus.mem_read, 1'b0);
      next_cyc();
      for (int c = 1; c <= 5; c++) begin
         bus.mem_ready = (c == 5);
         bus.mem_rdata = (c == 5) ? {16{8'hA5}} : 128'(0);
         @(negedge clk);
         chk1($sformatf("iread_c%0d_mem_read", c), bus.mem_read, 1'b1);
         chkw($sformatf("iread_c%0d_mem_addr", c), 128'(bus.mem_addr), 128'(28'h0000123));
         chk1($sformatf("iread_c%0d_i_ready", c), bus.i_ready, c == 5);
         chk1($sformatf("iread_c%0d_d_ready", c), bus.d_ready, 1'b0);
         if (c == 5) chkw("iread_rdata", bus.i_rdata, {16{8'hA5}});
         next_cyc();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk1("iread_recov_mem_read", bus.mem_read, 1'b0);
      chk1("iread_err", bus.err_timeout, 1'b0);
      next_cyc();
      next_cyc();

      // ---------------- simultaneous I read and D write ----------------
      bus.d_addr  = 28'h0ABCDEF;
      bus.d_wdata = {4{32'hCAFE_F00D}};
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk1("both_c0_idle", bus.mem_write | bus.mem_read, 1'b0);
      next_cyc();
      @(negedge clk);
      chk1("both_c1_mw", bus.mem_write, 1'b1);
      chk1("both_c1_mr", bus.mem_read, 1'b0);
      chkw("both_c1_addr", 128'(bus.mem_addr), 128'(28'h0ABCDEF));
      chkw("both_c1_wdata", bus.mem_wdata, {4{32'hCAFE_F00D}});
      next_cyc();
      bus.mem_ready = 1'b1;
      @(negedge clk);
      chk1("both_c2_d_ready", bus.d_ready, 1'b1);
      chk1("both_c2_i_ready", bus.i_ready, 1'b0);
      next_cyc();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk1("both_c3_recov", bus.mem_read | bus.mem_write, 1'b0);
      next_cyc();
      @(negedge clk);
      chk1("both_c4_idle", bus.mem_read, 1'b0);
      next_cyc();
      @(negedge clk);
      chk1("both_c5_gnt_i", bus.mem_read, 1'b1);
      chkw("both_c5_addr", 128'(bus.mem_addr), 128'(28'h0000123));
      next_cyc();
      bus.mem_ready = 1'b1;
      next_cyc();

      // ---------------- continuous contention: grant order ----------------
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 12; c++) begin
         bus.mem_ready = ((c % 3) == 1);
         @(negedge clk);
         if ((c % 3) == 1) begin
`ifdef MEM_ARB_RR_EN
            exp_d = ((c / 3) % 2) == 0;
`else
            exp_d = 1'b1;
`endif
            chk1($sformatf("order%0d_d_ready", c / 3), bus.d_ready, exp_d);
            chk1($sformatf("order%0d_i_ready", c / 3), bus.i_ready, !exp_d);
         end
         next_cyc();
      end

      // ---------------- watchdog with TIMEOUT=8 ----------------
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      next_cyc();
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk1($sformatf("wdog_stall%0d_err", c), bus.err_timeout, 1'b0);
         next_cyc();
      end
      bus.mem_ready = 1'b1;
      @(negedge clk);
      chk1("wdog_err_set", bus.err_timeout, 1'b1);
      chk1("wdog_not_aborted", bus.d_ready, 1'b1);
      next_cyc();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) next_cyc();
      @(negedge clk);
      chk1("wdog_err_sticky", bus.err_timeout, 1'b1);
      #2;
      proc_reset_n = 1'b0;
      #1;
      chk1("wdog_err_cleared", bus.err_timeout, 1'b0);
      next_cyc();
      proc_reset_n = 1'b1;

      // ---------------- randomized traffic vs reference model ----------------
      for (int r = 0; r < 4; r++) begin
         do_reset();
         d_act = 1'b0;
         for (int c = 0; c < 500; c++) begin
            if (bus.i_read) bus.i_read = ($urandom_range(0, 7) != 0);
            else            bus.i_read = ($urandom_range(0, 1) != 0);
            if (d_act) begin
               d_act = ($urandom_range(0, 7) != 0);
            end else begin
               d_act = ($urandom_range(0, 1) != 0);
               if (d_act) begin
                  case ($urandom_range(0, 2))
                     0:       begin bus.d_read = 1'b1; bus.d_write = 1'b0; end
                     1:       begin bus.d_read = 1'b0; bus.d_write = 1'b1; end
                     default: begin bus.d_read = 1'b1; bus.d_write = 1'b1; end
                  endcase
               end
            end
            if (!d_act) begin
               bus.d_read  = 1'b0;
               bus.d_write = 1'b0;
            end
            bus.i_addr    = ADDR_W'($urandom());
            bus.d_addr    = ADDR_W'($urandom());
            bus.d_wdata   = rnd128();
            bus.mem_rdata = rnd128();
            bus.mem_ready = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            check_model();
            model_step();
            next_cyc();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
